// File: rtl/friet_pkg.sv
// Shared definitions for the FRIET output-stream arbiter: FSM encodings,
// the message block counter saturation value and a grant decode helper.
package friet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [7:0] MSG_BLOCKS_MAX = 8'd255;

  // One-hot owner code derived from the arbiter state; 2'b00 while idle.
  function automatic logic [1:0] grant_of(input arb_state_t st);
    logic [1:0] g;
    g = 2'b00;
    if (st == ST_OWN0) g = 2'b01;
    if (st == ST_OWN1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/friet_stream_out_reg.sv
// Single-entry output register stage. A block loaded with 'load' appears on
// the outputs the following cycle. 'space' tells the producer that a load is
// allowed this cycle: either the register is empty or its content is being
// popped by the downstream consumer in the same cycle (full throughput).
module friet_stream_out_reg #(
  parameter int DATA_WIDTH = 128,
  parameter int SIZE_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [SIZE_WIDTH-1:0] load_size,
  input  logic                  load_last,
  output logic                  space,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [SIZE_WIDTH-1:0] dout_size,
  output logic                  dout_last,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  assign space = !dout_valid || dout_ready;

  // Control half of the pipe: valid/size/last, cleared by reset so a held
  // block is discarded when the stream is reset mid-message.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout_size  <= '0;
      dout_last  <= 1'b0;
    end else if (load) begin
      dout_valid <= 1'b1;
      dout_size  <= load_size;
      dout_last  <= load_last;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Data half of the pipe: no reset needed, qualified by dout_valid.
  always_ff @(posedge clk) begin
    if (load) begin
      dout <= load_data;
    end
  end

endmodule

// File: rtl/friet_stream_out_arbiter.sv
// Message-granular arbiter merging the ciphertext (channel 0) and tag
// (channel 1) block streams into one registered output stream.
//
// Handshake: on every din*/dout interface a block moves on a rising clk edge
// exactly when valid and ready are both 1 in the cycle before that edge;
// valid never depends on ready, and a producer keeps its block stable until
// it is taken.
//
// Ownership is granted in IDLE (round-robin on contention) and held until the
// owner's last block is accepted, so messages are never interleaved. The
// one-hot 'grant' output mirrors the FSM state for observation.
module friet_stream_out_arbiter
  import friet_pkg::*;
#(
  parameter int DIN_WIDTH      = 128,
  parameter int DIN_SIZE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIN_WIDTH-1:0]    din0,
  input  logic [DIN_SIZE_WIDTH:0] din0_size,
  input  logic                    din0_last,
  input  logic                    din0_valid,
  output logic                    din0_ready,
  input  logic [DIN_WIDTH-1:0]    din1,
  input  logic [DIN_SIZE_WIDTH:0] din1_size,
  input  logic                    din1_last,
  input  logic                    din1_valid,
  output logic                    din1_ready,
  output logic [DIN_WIDTH-1:0]    dout,
  output logic [DIN_SIZE_WIDTH:0] dout_size,
  output logic                    dout_last,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [1:0]              grant,
  output logic [7:0]              msg_blocks
);

  arb_state_t                state;
  arb_state_t                state_next;
  logic                      rr;
  logic                      space;
  logic                      accept;
  logic [DIN_WIDTH-1:0]      sel_data;
  logic [DIN_SIZE_WIDTH:0]   sel_size;
  logic                      sel_last;

  assign grant = grant_of(state);

  // Next-state, upstream ready and owner data mux. Readies are forced low
  // while reset is asserted because the state register only clears on the edge.
  always_comb begin
    state_next = state;
    din0_ready = 1'b0;
    din1_ready = 1'b0;
    accept     = 1'b0;
    sel_data   = din0;
    sel_size   = din0_size;
    sel_last   = din0_last;
    case (state)
      ST_IDLE: begin
        if (din0_valid && din1_valid) state_next = rr ? ST_OWN1 : ST_OWN0;
        else if (din0_valid)          state_next = ST_OWN0;
        else if (din1_valid)          state_next = ST_OWN1;
      end
      ST_OWN0: begin
        din0_ready = rst_n && space;
        accept     = din0_valid && din0_ready;
        if (accept && din0_last) state_next = ST_IDLE;
      end
      ST_OWN1: begin
        din1_ready = rst_n && space;
        accept     = din1_valid && din1_ready;
        sel_data   = din1;
        sel_size   = din1_size;
        sel_last   = din1_last;
        if (accept && din1_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and round-robin pointer: after a message ends the other
  // channel becomes preferred.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && sel_last) rr <= (state == ST_OWN0);
    end
  end

  // Per-message block counter: cleared when ownership starts, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_blocks <= 8'd0;
    end else if (state == ST_IDLE && state_next != ST_IDLE) begin
      msg_blocks <= 8'd0;
    end else if (accept && msg_blocks != MSG_BLOCKS_MAX) begin
      msg_blocks <= msg_blocks + 8'd1;
    end
  end

  friet_stream_out_reg #(
    .DATA_WIDTH (DIN_WIDTH),
    .SIZE_WIDTH (DIN_SIZE_WIDTH + 1)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_data  (sel_data),
    .load_size  (sel_size),
    .load_last  (sel_last),
    .space      (space),
    .dout       (dout),
    .dout_size  (dout_size),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

endmodule
